mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, max ACCESS cycles waiting for Mem_Ready before abort (range 2..31).
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low; Reset=0 forces reset state immediately.
REQ-004 IF_Req  in  1  instruction-fetch read request; held high until IF_Ack.
REQ-005 IF_Addr  in  32  fetch byte address.
REQ-006 IF_Ack  out  1  one-cycle completion pulse to fetch requester.
REQ-007 IF_RData  out  32  registered fetch read data.
REQ-008 LS_Req  in  1  load/store request; held high until LS_Ack.
REQ-009 LS_We  in  1  1=store, 0=load.
REQ-010 LS_Addr  in  32  load/store byte address.
REQ-011 LS_WData  in  32  store data.
REQ-012 LS_Ack  out  1  one-cycle completion pulse to load/store requester.
REQ-013 LS_RData  out  32  registered load read data.
REQ-014 Mem_En  out  1  memory access strobe.
REQ-015 Mem_We  out  1  memory write enable.
REQ-016 Mem_Addr  out  32  memory address.
REQ-017 Mem_WData  out  32  memory write data.
REQ-018 Mem_RData  in  32  memory read data, valid when Mem_Ready=1.
REQ-019 Mem_Ready  in  1  memory completion for current access.
REQ-020 Busy  out  1  high whenever state is not IDLE.
REQ-021 Timeout_Err  out  1  sticky flag, set on any timed-out access.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-023 IDLE: if any Req high at edge, grant one, latch its Addr/We/WData (IF: We=0, WData=0) into internal regs, clear wait counter, go ACCESS; else stay.
REQ-024 Arbitration round-robin: single request granted directly; both high -> grant the requester not granted last; last-grant reset value = IF (so LS wins first contention).
REQ-025 ACCESS: Mem_En=1, Mem_We/Mem_Addr/Mem_WData driven from latched regs only, stable all ACCESS cycles; Mem_* = 0 in IDLE and RESP.
REQ-026 ACCESS with Mem_Ready=1 at edge: load (We=0) captures Mem_RData into granted requester's RData reg; store leaves RData regs unchanged; go RESP.
REQ-027 ACCESS, Mem_Ready=0: counter increments; at counter = TIMEOUT_CYC-1 without Mem_Ready -> set Timeout_Err, granted RData reg <= 0 (loads and fetches), go RESP.
REQ-028 RESP: granted Ack=1 for exactly this one cycle, other Ack=0; then IDLE unconditionally.
REQ-029 Minimum latency: Req sampled at edge 0, Mem_Ready high in first ACCESS cycle -> Ack high in cycle 2; each extra wait cycle adds one.
REQ-030 RData regs hold value until next capture for same requester; never change on other requester's transaction.
REQ-031 Req deasserted mid-transaction ignored; transaction completes and Ack still pulses.
REQ-032 Latched Addr/WData changes on input ports after grant have no effect.
REQ-033 Mem_Ready in IDLE/RESP ignored.
REQ-034 Timeout_Err cleared only by reset.

Reset
REQ-035 Reset=0: state IDLE, all outputs 0 (Acks, Busy, Mem_*, RData regs, Timeout_Err), last-grant=IF, counter 0, independent of CLK.
REQ-036 Reset mid-ACCESS aborts transaction; no Ack issued; after release, arbiter resumes from IDLE.

Verification
REQ-037 IF_Req, IF_Addr=0x0000_0040, Mem_Ready in first ACCESS cycle, Mem_RData=0x2002_0005 -> Mem_En 1 cycle, IF_Ack pulse in cycle 2, IF_RData=0x2002_0005.
REQ-038 IF_Req and LS_Req both high from reset, LS_We=1, LS_Addr=0x100, LS_WData=0xDEAD_BEEF -> LS granted first (Mem_We=1, Mem_WData=0xDEADBEEF), then IF; IF_RData unchanged by store.
REQ-039 Both Reqs held continuously for 4 transactions -> grant order LS, IF, LS, IF.
REQ-040 LS load, Mem_Ready delayed 3 cycles -> Mem_Addr stable 4 ACCESS cycles, LS_Ack in cycle 5.
REQ-041 Mem_Ready held 0, TIMEOUT_CYC=16 -> after 16 ACCESS cycles Timeout_Err=1, Ack pulses, RData=0; flag persists after next good access.
REQ-042 Reset=0 asserted asynchronously during ACCESS -> Mem_En, Busy drop before next edge; no Ack; next request serviced normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and memory-side signals for mem_arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, ls_ack, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               busy, timeout_err
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, ls_ack, ls_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of fetch and load/store ports onto one memory,
// one transaction in flight, with a wait-cycle timeout.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        tout_q, tout_d;
    logic        sel_ls;
    logic        acc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            tout_q     <= tout_d;
        end
    end

    // gnt_q: 1 = load/store, 0 = fetch; doubles as the last-grant pointer
    assign sel_ls = bus.ls_req & (~bus.if_req | ~gnt_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        tout_d     = tout_q;
        unique case (state_q)
            IDLE: if (bus.if_req | bus.ls_req) begin
                state_d = ACCESS;
                gnt_d   = sel_ls;
                we_d    = sel_ls & bus.ls_we;
                addr_d  = sel_ls ? bus.ls_addr : bus.if_addr;
                wdata_d = sel_ls ? bus.ls_wdata : 32'h0;
                cnt_d   = '0;
            end
            ACCESS: if (bus.mem_ready) begin
                state_d = RESP;
                if (!we_q && gnt_q) ls_rdata_d = bus.mem_rdata;
                if (!we_q && !gnt_q) if_rdata_d = bus.mem_rdata;
            end else if (cnt_q == 5'(TIMEOUT_CYC - 1)) begin
                state_d = RESP;
                tout_d  = 1'b1;
                if (!we_q && gnt_q) ls_rdata_d = '0;
                if (!we_q && !gnt_q) if_rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign acc = state_q == ACCESS;

    always_comb begin
        bus.busy        = state_q != IDLE;
        bus.mem_en      = acc;
        bus.mem_we      = acc & we_q;
        bus.mem_addr    = acc ? addr_q : 32'h0;
        bus.mem_wdata   = acc ? wdata_q : 32'h0;
        bus.if_ack      = (state_q == RESP) & ~gnt_q;
        bus.ls_ack      = (state_q == RESP) & gnt_q;
        bus.if_rdata    = if_rdata_q;
        bus.ls_rdata    = ls_rdata_q;
        bus.timeout_err = tout_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-by-cycle checks of mem_arbiter arbitration,
// latency, timeout and asynchronous reset behaviour.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        #3;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_if_ack", 32'(bus.if_ack), 0);
        check("rst_ls_ack", 32'(bus.ls_ack), 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_ls_rdata", bus.ls_rdata, 0);
        check("rst_tout", 32'(bus.timeout_err), 0);
        tick();
        rst_n = 1'b1;

        // Minimum-latency fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        tick();
        check("f_mem_en", 32'(bus.mem_en), 1);
        check("f_mem_addr", bus.mem_addr, 32'h40);
        check("f_mem_we", 32'(bus.mem_we), 0);
        check("f_busy", 32'(bus.busy), 1);
        check("f_ack_early", 32'(bus.if_ack), 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h2002_0005;
        tick();
        check("f_if_ack", 32'(bus.if_ack), 1);
        check("f_ls_ack", 32'(bus.ls_ack), 0);
        check("f_mem_en_resp", 32'(bus.mem_en), 0);
        check("f_mem_addr_resp", bus.mem_addr, 0);
        check("f_if_rdata", bus.if_rdata, 32'h2002_0005);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("f_ack_done", 32'(bus.if_ack), 0);
        check("f_idle", 32'(bus.busy), 0);

        // Contention right after reset: LS store first, then IF
        rst_n = 1'b0;
        #1;
        check("c_rst_if_rdata", bus.if_rdata, 0);
        rst_n        = 1'b1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h200;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 32'h100;
        bus.ls_wdata = 32'hDEAD_BEEF;
        tick();
        check("c_mem_we", 32'(bus.mem_we), 1);
        check("c_mem_addr", bus.mem_addr, 32'h100);
        check("c_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        tick();
        check("c_ls_ack", 32'(bus.ls_ack), 1);
        check("c_if_ack", 32'(bus.if_ack), 0);
        check("c_ls_rdata_store", bus.ls_rdata, 0);
        check("c_if_rdata_store", bus.if_rdata, 0);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("c_idle_gap", 32'(bus.busy), 0);
        tick();
        check("c_if_addr", bus.mem_addr, 32'h200);
        check("c_if_we", 32'(bus.mem_we), 0);
        check("c_if_wdata", bus.mem_wdata, 0);
        bus.if_addr = 32'hFFFF_FFFF;
        tick();
        check("c_addr_latched", bus.mem_addr, 32'h200);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE_0001;
        tick();
        check("c_if_ack2", 32'(bus.if_ack), 1);
        check("c_if_rdata", bus.if_rdata, 32'hCAFE_0001);
        check("c_ls_rdata_keep", bus.ls_rdata, 0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Continuous contention: LS, IF, LS, IF
        bus.if_addr = 32'h300;
        bus.ls_addr = 32'h400;
        bus.ls_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.ls_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_addr%0d", k), bus.mem_addr, (k % 2 == 0) ? 32'h400 : 32'h300);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'h1000 + 32'(k);
            tick();
            check($sformatf("rr_ls_ack%0d", k), 32'(bus.ls_ack), (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr_if_ack%0d", k), 32'(bus.if_ack), (k % 2 == 0) ? 0 : 1);
            bus.mem_ready = 1'b0;
            tick();
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        check("rr_if_rdata", bus.if_rdata, 32'h1003);
        check("rr_ls_rdata", bus.ls_rdata, 32'h1002);

        // LS load with three wait cycles
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h500;
        tick();
        check("w_addr0", bus.mem_addr, 32'h500);
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("w_addr%0d", k), bus.mem_addr, 32'h500);
            check($sformatf("w_noack%0d", k), 32'(bus.ls_ack), 0);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        check("w_ls_ack", 32'(bus.ls_ack), 1);
        check("w_ls_rdata", bus.ls_rdata, 32'h0BAD_F00D);
        check("w_if_rdata_keep", bus.if_rdata, 32'h1003);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Fetch timeout after 16 ACCESS cycles
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        tick();
        repeat (15) tick();
        check("t_still_access", 32'(bus.mem_en), 1);
        check("t_not_yet", 32'(bus.timeout_err), 0);
        tick();
        check("t_if_ack", 32'(bus.if_ack), 1);
        check("t_err", 32'(bus.timeout_err), 1);
        check("t_if_rdata", bus.if_rdata, 0);
        bus.if_req = 1'b0;
        tick();
        bus.ls_req = 1'b1;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h55;
        tick();
        check("t_good_ack", 32'(bus.ls_ack), 1);
        check("t_sticky", 32'(bus.timeout_err), 1);
        check("t_good_rdata", bus.ls_rdata, 32'h55);
        bus.ls_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Asynchronous reset during ACCESS
        bus.ls_req = 1'b1;
        tick();
        check("r_mem_en", 32'(bus.mem_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_mem_en_drop", 32'(bus.mem_en), 0);
        check("r_busy_drop", 32'(bus.busy), 0);
        check("r_tout_clr", 32'(bus.timeout_err), 0);
        check("r_ls_rdata_clr", bus.ls_rdata, 0);
        bus.ls_req = 1'b0;
        tick();
        rst_n = 1'b1;
        check("r_noack0", 32'(bus.ls_ack), 0);
        tick();
        check("r_noack1", 32'(bus.ls_ack), 0);
        check("r_idle", 32'(bus.busy), 0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h700;
        tick();
        check("r_next_addr", bus.mem_addr, 32'h700);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h77;
        tick();
        check("r_next_ack", 32'(bus.if_ack), 1);
        check("r_next_rdata", bus.if_rdata, 32'h77);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
